bram_dualport_selftest: RTL and testbench

//  Self-checking dual-port block-RAM subsystem: a Moore sequencer drives both ports of a
//  1024x16 true-dual-port RAM through write, cross-read, and collision checks.
//  It sits beside the CPU memory map as a bring-up and BIST unit.
//  All RAM port signals are exported for observation.

---
 rtl/bram_pkg.sv | 28 ++
 rtl/dp_bram.sv | 33 +++
 rtl/bram_dualport_selftest.sv | 98 +++++++++
 tb/tb_bram_dualport_selftest.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared constants for the dual-port BRAM self-test: geometry, sequencer states
// and the test patterns/addresses the sequencer drives.
package bram_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;

  // Code 3'd7 is left unused; the sequencer treats it as a fault.
  typedef enum logic [2:0] {
    S_WR   = 3'd0,
    S_RD   = 3'd1,
    S_CHK1 = 3'd2,
    S_COLL = 3'd3,
    S_RD2  = 3'd4,
    S_CHK2 = 3'd5,
    S_DONE = 3'd6
  } state_e;

  localparam logic [DATA_W-1:0] PAT_A = 16'h00AA;
  localparam logic [DATA_W-1:0] PAT_B = 16'h0055;
  localparam logic [DATA_W-1:0] PAT_C = 16'h1234;
  localparam logic [DATA_W-1:0] PAT_D = 16'h5678;

  localparam logic [ADDR_W-1:0] ADDR_LO  = 10'h000;
  localparam logic [ADDR_W-1:0] ADDR_MID = 10'h200;
  localparam logic [ADDR_W-1:0] ADDR_HI  = 10'h3FF;

endpackage

// File: rtl/dp_bram.sv
// True dual-port RAM, registered outputs. Same-port write-first; a cross-port
// read sees old data; on a same-address double write port A's data is kept.
module dp_bram
  import bram_pkg::*;
(
  input  logic              clk,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              b_blocked;

  assign b_blocked = we_a && (addr_a == addr_b);

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_a;
    if (we_b && !b_blocked) mem[addr_b] <= data_b;
  end

  // mem reads below sample the pre-edge contents, giving old data cross-port.
  always_ff @(posedge clk) begin
    q_a <= we_a ? data_a : mem[addr_a];
    q_b <= we_b ? data_b : mem[addr_b];
  end

endmodule

// File: rtl/bram_dualport_selftest.sv
// Bring-up BIST: a Moore sequencer exercises both ports of dp_bram once after
// reset and reports done/pass. RAM port signals are exported for observation.
module bram_dualport_selftest
  import bram_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              we_a,
  output logic              we_b,
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b,
  output logic              done,
  output logic              pass
);

  state_e state;
  logic   err;
  logic   we_a_dec;
  logic   we_b_dec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_WR;
      err   <= 1'b0;
    end else begin
      case (state)
        S_WR:   state <= S_RD;
        S_RD:   state <= S_CHK1;
        S_CHK1: begin
          err   <= err | (q_a != PAT_B) | (q_b != PAT_A);
          state <= S_COLL;
        end
        S_COLL: state <= S_RD2;
        S_RD2:  state <= S_CHK2;
        S_CHK2: begin
          err   <= err | (q_a != PAT_C) | (q_b != PAT_C);
          state <= S_DONE;
        end
        S_DONE: state <= S_DONE;
        default: begin
          err   <= 1'b1;
          state <= S_DONE;
        end
      endcase
    end
  end

  always_comb begin
    we_a_dec = 1'b0;
    we_b_dec = 1'b0;
    addr_a   = '0;
    addr_b   = '0;
    data_a   = '0;
    data_b   = '0;
    case (state)
      S_WR: begin
        we_a_dec = 1'b1;  addr_a = ADDR_LO;  data_a = PAT_A;
        we_b_dec = 1'b1;  addr_b = ADDR_MID; data_b = PAT_B;
      end
      S_RD: begin
        addr_a = ADDR_MID;
        addr_b = ADDR_LO;
      end
      S_COLL: begin
        we_a_dec = 1'b1;  addr_a = ADDR_HI; data_a = PAT_C;
        we_b_dec = 1'b1;  addr_b = ADDR_HI; data_b = PAT_D;
      end
      S_RD2: begin
        addr_a = ADDR_HI;
        addr_b = ADDR_HI;
      end
      default: ;
    endcase
  end

  // Gating by reset keeps the RAM from being written while the sequencer is held.
  assign we_a = we_a_dec & reset;
  assign we_b = we_b_dec & reset;
  assign done = (state == S_DONE);
  assign pass = done & ~err;

  dp_bram u_ram (
    .clk    (clk),
    .we_a   (we_a),
    .we_b   (we_b),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .data_a (data_a),
    .data_b (data_b),
    .q_a    (q_a),
    .q_b    (q_b)
  );

endmodule

// File: tb/tb_bram_dualport_selftest.sv
// Directed bench for bram_dualport_selftest: reset decode, normal pass, collision,
// mid-sequence reset abort, backdoor corruption and S_DONE hold.
module tb_bram_dualport_selftest;

  logic        clk;
  logic        reset;
  logic [15:0] data_a, data_b, q_a, q_b;
  logic [9:0]  addr_a, addr_b;
  logic        we_a, we_b, done, pass;

  int n_total = 0;
  int n_pass  = 0;

  bram_dualport_selftest dut (
    .clk    (clk),
    .reset  (reset),
    .data_a (data_a),
    .data_b (data_b),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .we_a   (we_a),
    .we_b   (we_b),
    .q_a    (q_a),
    .q_b    (q_b),
    .done   (done),
    .pass   (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // 1. reset held: S_WR decode with write strobes gated off
    reset = 1'b0;
    tick(2);
    check("rst_we_a", 32'(we_a), 32'h0);
    check("rst_we_b", 32'(we_b), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_pass", 32'(pass), 32'h0);
    check("rst_addr_a", 32'(addr_a), 32'h000);
    check("rst_addr_b", 32'(addr_b), 32'h200);
    check("rst_data_a", 32'(data_a), 32'h00AA);

    // 2. release: S_WR writes on first edge, cross-read on second
    reset = 1'b1;
    #1;
    check("wr_we_a", 32'(we_a), 32'h1);
    check("wr_we_b", 32'(we_b), 32'h1);
    tick(1);
    check("mem_0", 32'(dut.u_ram.mem[0]), 32'h00AA);
    check("mem_200", 32'(dut.u_ram.mem[10'h200]), 32'h0055);
    check("rd_addr_a", 32'(addr_a), 32'h200);
    check("rd_addr_b", 32'(addr_b), 32'h000);
    tick(1);
    check("chk1_q_a", 32'(q_a), 32'h0055);
    check("chk1_q_b", 32'(q_b), 32'h00AA);

    // 3. collision: A's data survives; done/pass after 6 edges
    tick(1);
    check("coll_we_a", 32'(we_a), 32'h1);
    check("coll_we_b", 32'(we_b), 32'h1);
    check("coll_data_a", 32'(data_a), 32'h1234);
    check("coll_data_b", 32'(data_b), 32'h5678);
    check("coll_addr_b", 32'(addr_b), 32'h3FF);
    tick(1);
    check("mem_3ff", 32'(dut.u_ram.mem[10'h3FF]), 32'h1234);
    check("rd2_done", 32'(done), 32'h0);
    tick(1);
    check("chk2_q_a", 32'(q_a), 32'h1234);
    check("chk2_q_b", 32'(q_b), 32'h1234);
    check("chk2_done", 32'(done), 32'h0);
    tick(1);
    check("run1_done", 32'(done), 32'h1);
    check("run1_pass", 32'(pass), 32'h1);

    // 4. reset asserted during S_RD2 aborts immediately
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(4);
    check("mid_pre_done", 32'(done), 32'h0);
    #2;
    reset = 1'b0;
    #1;
    check("abort_we_a", 32'(we_a), 32'h0);
    check("abort_we_b", 32'(we_b), 32'h0);
    check("abort_addr_b", 32'(addr_b), 32'h200);
    check("abort_done", 32'(done), 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    tick(5);
    check("rerun_not_done", 32'(done), 32'h0);
    tick(1);
    check("rerun_done", 32'(done), 32'h1);
    check("rerun_pass", 32'(pass), 32'h1);

    // 5. corrupt RAM[0x200] after the S_WR write, before S_RD reads it
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    dut.u_ram.mem[10'h200] = 16'hFFFF;
    tick(1);
    check("corr_q_a", 32'(q_a), 32'hFFFF);
    tick(4);
    check("corr_done", 32'(done), 32'h1);
    check("corr_pass", 32'(pass), 32'h0);

    // 6. S_DONE holds with no write strobes
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("hold_done", 32'(done), 32'h1);
      check("hold_pass", 32'(pass), 32'h0);
      check("hold_we", 32'({we_a, we_b}), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
